// File: rtl/ram_copy_dma_pkg.sv
// ram_copy_dma_pkg: shared state encoding and default RAM address width.
package ram_copy_dma_pkg;
  localparam int ADDR_W = 16;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/ram_copy_dma_if.sv
// ram_copy_dma_if: RAM control lines plus the arbiter request/grant pair.
interface ram_copy_dma_if #(parameter int W = ram_copy_dma_pkg::ADDR_W) ();
  logic         cs;
  logic         we;
  logic [W-1:0] addr;
  logic         bus_req;
  logic         bus_grant;
  modport master (output cs, we, addr, bus_req, input bus_grant);
  modport slave  (input cs, we, addr, bus_req, output bus_grant);
endinterface

// File: rtl/ram_copy_dma.sv
// ram_copy_dma: forward byte-by-byte RAM-to-RAM copy engine, bus gained via request/grant.
import ram_copy_dma_pkg::*;
module ram_copy_dma #(
  parameter int BITS = ADDR_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [BITS-1:0] src_addr_i,
  input  logic [BITS-1:0] dst_addr_i,
  input  logic [BITS-1:0] length_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [BITS-1:0] remaining_o,
  inout  wire  [7:0]      ram_data_io,
  ram_copy_dma_if.master  bus
);
  state_e          state_q;
  logic [BITS-1:0] src_q, dst_q, rem_q;
  logic [7:0]      hold_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          src_q   <= src_addr_i;
          dst_q   <= dst_addr_i;
          rem_q   <= length_i;
          state_q <= (length_i == '0) ? DONE : REQ;
        end
        REQ: if (bus.bus_grant) state_q <= READ;
        READ: begin
          hold_q  <= ram_data_io;
          state_q <= WRITE;
        end
        // grant is only re-sampled here, so a read/write pair is never split
        WRITE: begin
          src_q   <= src_q + BITS'(1);
          dst_q   <= dst_q + BITS'(1);
          rem_q   <= rem_q - BITS'(1);
          state_q <= (rem_q == BITS'(1)) ? DONE : (bus.bus_grant ? READ : REQ);
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  assign bus.cs      = (state_q == READ) || (state_q == WRITE);
  assign bus.we      = (state_q == WRITE);
  assign bus.addr    = (state_q == READ) ? src_q : (state_q == WRITE) ? dst_q : '0;
  assign bus.bus_req = (state_q == REQ) || (state_q == READ) || (state_q == WRITE);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign remaining_o = rem_q;
  assign ram_data_io = (state_q == WRITE) ? hold_q : 8'hzz;
endmodule

// File: tb/tb_ram_copy_dma.sv
// tb_ram_copy_dma: directed checks of the copy engine against a behavioural RAM.
module tb_ram_copy_dma;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src = '0, dst = '0, len = '0;
  logic        busy, done;
  logic [15:0] remaining;
  wire  [7:0]  ram_data;
  logic [7:0]  mem [0:65535];
  int          tests = 0;
  int          fails = 0;
  int          cyc;

  ram_copy_dma_if #(.W(16)) rif ();

  ram_copy_dma #(.BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start),
    .src_addr_i(src), .dst_addr_i(dst), .length_i(len),
    .busy_o(busy), .done_o(done), .remaining_o(remaining),
    .ram_data_io(ram_data), .bus(rif.master)
  );

  always #5 clk = ~clk;

  // RAM drives on reads; a CPU-side driver holds 00 whenever the RAM is deselected
  assign ram_data = rif.cs ? (rif.we ? 8'hzz : mem[rif.addr]) : 8'h00;
  always @(posedge clk) if (rif.cs && rif.we) mem[rif.addr] <= ram_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    src = s; dst = d; len = l; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    rif.bus_grant = 1'b0;
    step(2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", rif.bus_req, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_cs_we", {rif.cs, rif.we}, 0);
    chk("rst_addr", rif.addr, 0);
    chk("rst_data", ram_data, 8'h00);
    rst_n = 1'b1;
    step(1);

    mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22; mem[16'h0102] = 8'h33; mem[16'h0103] = 8'h44;
    rif.bus_grant = 1'b1;
    start_copy(16'h0100, 16'h0200, 16'd4);
    chk("basic_busy", busy, 1);
    chk("basic_req", rif.bus_req, 1);
    chk("basic_rem", remaining, 4);
    chk("basic_idlebus", rif.cs, 0);
    step(1);
    chk("basic_read", {rif.cs, rif.we, rif.addr}, {2'b10, 16'h0100});
    step(1);
    chk("basic_write", {rif.cs, rif.we, rif.addr}, {2'b11, 16'h0200});
    chk("basic_wdata", ram_data, 8'h11);
    wait_done(cyc);
    chk("basic_latency", cyc + 3, 10);
    chk("basic_done_req", rif.bus_req, 0);
    chk("basic_done_busy", busy, 1);
    step(1);
    chk("basic_after", {busy, done}, 0);
    chk("basic_mem", {mem[16'h0200], mem[16'h0201], mem[16'h0202], mem[16'h0203]}, 32'h11223344);

    start_copy(16'h1234, 16'h5678, 16'd0);
    chk("zero_done", done, 1);
    chk("zero_req", rif.bus_req, 0);
    chk("zero_cs", rif.cs, 0);
    chk("zero_rem", remaining, 0);
    step(1);
    chk("zero_after", {busy, done}, 0);

    mem[16'hFFFE] = 8'hA1; mem[16'hFFFF] = 8'hA2; mem[16'h0000] = 8'hA3; mem[16'h0001] = 8'hA4;
    start_copy(16'hFFFE, 16'h0010, 16'd4);
    wait_done(cyc);
    chk("wrap_latency", cyc + 1, 10);
    chk("wrap_mem", {mem[16'h0010], mem[16'h0011], mem[16'h0012], mem[16'h0013]}, 32'hA1A2A3A4);
    step(1);

    mem[16'h0600] = 8'hC1; mem[16'h0601] = 8'hC2; mem[16'h0602] = 8'hC3;
    start_copy(16'h0600, 16'h0700, 16'd3);
    step(2);
    chk("gnt_first_write", rif.we, 1);
    rif.bus_grant = 1'b0;
    step(1);
    for (int i = 0; i < 5; i++) begin
      chk("gnt_pause_cs", rif.cs, 0);
      chk("gnt_pause_req", rif.bus_req, 1);
      chk("gnt_pause_rem", remaining, 2);
      chk("gnt_pause_data", ram_data, 8'h00);
      if (i < 4) step(1);
    end
    rif.bus_grant = 1'b1;
    step(1);
    chk("gnt_resume", {rif.cs, rif.we, rif.addr}, {2'b10, 16'h0601});
    wait_done(cyc);
    chk("gnt_latency", cyc, 4);
    chk("gnt_mem", {mem[16'h0700], mem[16'h0701], mem[16'h0702]}, 24'hC1C2C3);
    step(1);

    mem[16'h0300] = 8'h5A;
    for (int i = 1; i <= 8; i++) mem[16'h0300 + 16'(i)] = 8'h00;
    start_copy(16'h0300, 16'h0301, 16'd8);
    wait_done(cyc);
    chk("fill_latency", cyc + 1, 18);
    for (int i = 1; i <= 8; i++) chk("fill_mem", mem[16'h0300 + 16'(i)], 8'h5A);
    step(1);

    for (int i = 0; i < 16; i++) begin
      mem[16'h0400 + 16'(i)] = 8'h80 + 8'(i);
      mem[16'h0800 + 16'(i)] = 8'h00;
    end
    start_copy(16'h0400, 16'h0800, 16'd16);
    start_copy(16'h0500, 16'h0900, 16'd1);
    chk("ign_rem", remaining, 16);
    chk("ign_addr", rif.addr, 16'h0400);
    step(1);
    chk("rstmid_write", {rif.we, rif.addr}, {1'b1, 16'h0800});
    chk("rstmid_wdata", ram_data, 8'h80);
    rst_n = 1'b0;
    #1;
    chk("rstmid_cs_we", {rif.cs, rif.we}, 0);
    chk("rstmid_data", ram_data, 8'h00);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_req", rif.bus_req, 0);
    chk("rstmid_rem", remaining, 0);
    step(1);
    rst_n = 1'b1;
    chk("rstmid_nowrite", {mem[16'h0800], mem[16'h0801]}, 16'h0000);
    start_copy(16'h0400, 16'h0A00, 16'd2);
    wait_done(cyc);
    chk("rstmid_new_lat", cyc + 1, 6);
    chk("rstmid_new_mem", {mem[16'h0A00], mem[16'h0A01]}, 16'h8081);
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
